bayer_window_5x5: RTL

//  Raster-stream to 5x5 neighbourhood generator for the CFA pipeline. Accepts one raw Bayer pixel per

---
 rtl/bayer_window_5x5_pkg.sv | 18 +
 rtl/bayer_window_5x5_cfa_line_buffer.sv | 25 ++
 rtl/bayer_window_5x5.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bayer_window_5x5_pkg.sv
// Shared types and constants for the 5x5 Bayer window generator.
// The row and column counter widths are derived from the image dimensions with dim_w().
package bayer_window_5x5_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_e;

    localparam int WIN   = 5;
    localparam int LINES = WIN - 1;

    function automatic int dim_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bayer_window_5x5_cfa_line_buffer.sv
// One raster line of storage: read-before-write at a shared address, so rd_data is the
// pixel that was written one line earlier at the same column.
module cfa_line_buffer #(
    parameter int DEPTH  = 640,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rd_data = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/bayer_window_5x5.sv
// Raster pixel stream to registered 5x5 neighbourhood with centre coordinates.
// Four cascaded line buffers supply the vertical taps; a 5x4 history supplies the horizontal ones.
module bayer_window_5x5
    import bayer_window_5x5_pkg::*;
#(
    parameter int pixelBitWidth = 12,
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    localparam int ROW_W        = dim_w(IMG_HEIGHT),
    localparam int COL_W        = dim_w(IMG_WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [pixelBitWidth-1:0] pix_in,
    input  logic                     pix_valid,
    output logic [pixelBitWidth-1:0] p_m2_m2, p_m2_m1, p_m2_p0, p_m2_p1, p_m2_p2,
    output logic [pixelBitWidth-1:0] p_m1_m2, p_m1_m1, p_m1_p0, p_m1_p1, p_m1_p2,
    output logic [pixelBitWidth-1:0] p_p0_m2, p_p0_m1, p_p0_p0, p_p0_p1, p_p0_p2,
    output logic [pixelBitWidth-1:0] p_p1_m2, p_p1_m1, p_p1_p0, p_p1_p1, p_p1_p2,
    output logic [pixelBitWidth-1:0] p_p2_m2, p_p2_m1, p_p2_p0, p_p2_p1, p_p2_p2,
    output logic                     win_valid,
    output logic [ROW_W-1:0]         cen_row,
    output logic [COL_W-1:0]         cen_col,
    output logic                     frame_done
);

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d, cur_row, cen_row_q, cen_row_d;
    logic [COL_W-1:0]         col_q, col_d, cur_col, cen_col_q, cen_col_d;
    logic                     win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic                     restart, accept, at_eol, at_eof;
    logic [pixelBitWidth-1:0] tap [WIN];
    logic [pixelBitWidth-1:0] hist_q [WIN][LINES];
    logic [pixelBitWidth-1:0] hist_d [WIN][LINES];
    logic [pixelBitWidth-1:0] win_q  [WIN][WIN];
    logic [pixelBitWidth-1:0] win_d  [WIN][WIN];

    // tap[i] carries row r-i at the current column; tap[0] is the live pixel.
    assign tap[0] = pix_in;

    for (genvar i = 0; i < LINES; i++) begin : g_lb
        cfa_line_buffer #(
            .DEPTH  (IMG_WIDTH),
            .DATA_W (pixelBitWidth),
            .ADDR_W (COL_W)
        ) u_lb (
            .clk     (clk),
            .we      (accept),
            .addr    (cur_col),
            .wr_data (tap[i]),
            .rd_data (tap[i+1])
        );
    end

    // A start outside DONE re-anchors the frame so the pixel presented with it is (0,0).
    always_comb begin
        restart = start && (state_q != S_DONE);
        accept  = pix_valid && (restart || (state_q == S_ACTIVE));
        cur_row = restart ? '0 : row_q;
        cur_col = restart ? '0 : col_q;
        at_eol  = (cur_col == COL_W'(IMG_WIDTH - 1));
        at_eof  = at_eol && (cur_row == ROW_W'(IMG_HEIGHT - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_ACTIVE;
            S_ACTIVE: if (!restart && accept && at_eof) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row_d = cur_row;
        col_d = cur_col;
        if (accept) begin
            if (at_eol) begin
                col_d = '0;
                row_d = at_eof ? '0 : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + COL_W'(1);
            end
        end
    end

    always_comb begin
        hist_d       = hist_q;
        win_d        = win_q;
        cen_row_d    = cen_row_q;
        cen_col_d    = cen_col_q;
        frame_done_d = (state_q == S_DONE);
        win_valid_d  = accept && !restart && (cur_row >= ROW_W'(LINES)) && (cur_col >= COL_W'(LINES));
        if (accept) begin
            for (int k = 0; k < WIN; k++) begin
                for (int j = 0; j < LINES - 1; j++) begin
                    hist_d[k][j] = hist_q[k][j+1];
                end
                hist_d[k][LINES-1] = tap[LINES-k];
            end
        end
        // Window registers only load on a complete neighbourhood, so they hold otherwise.
        if (win_valid_d) begin
            for (int k = 0; k < WIN; k++) begin
                for (int j = 0; j < LINES; j++) begin
                    win_d[k][j] = hist_q[k][j];
                end
                win_d[k][LINES] = tap[LINES-k];
            end
            cen_row_d = cur_row - ROW_W'(2);
            cen_col_d = cur_col - COL_W'(2);
        end
    end

    always_ff @(posedge clk) begin
        hist_q <= hist_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            col_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            cen_row_q    <= '0;
            cen_col_q    <= '0;
            win_q        <= '{default: '0};
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            cen_row_q    <= cen_row_d;
            cen_col_q    <= cen_col_d;
            win_q        <= win_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;
    assign cen_row    = cen_row_q;
    assign cen_col    = cen_col_q;

    assign p_m2_m2 = win_q[0][0];
    assign p_m2_m1 = win_q[0][1];
    assign p_m2_p0 = win_q[0][2];
    assign p_m2_p1 = win_q[0][3];
    assign p_m2_p2 = win_q[0][4];
    assign p_m1_m2 = win_q[1][0];
    assign p_m1_m1 = win_q[1][1];
    assign p_m1_p0 = win_q[1][2];
    assign p_m1_p1 = win_q[1][3];
    assign p_m1_p2 = win_q[1][4];
    assign p_p0_m2 = win_q[2][0];
    assign p_p0_m1 = win_q[2][1];
    assign p_p0_p0 = win_q[2][2];
    assign p_p0_p1 = win_q[2][3];
    assign p_p0_p2 = win_q[2][4];
    assign p_p1_m2 = win_q[3][0];
    assign p_p1_m1 = win_q[3][1];
    assign p_p1_p0 = win_q[3][2];
    assign p_p1_p1 = win_q[3][3];
    assign p_p1_p2 = win_q[3][4];
    assign p_p2_m2 = win_q[4][0];
    assign p_p2_m1 = win_q[4][1];
    assign p_p2_p0 = win_q[4][2];
    assign p_p2_p1 = win_q[4][3];
    assign p_p2_p2 = win_q[4][4];

endmodule
